rob_param: RTL and testbench
============================

Name: rob_param

Overview:
- Parametrised reorder buffer for the Tomasulo core; successor to the fixed 8-entry ROB.
- Allocates entries in program order at dispatch and captures CDB results, registered.
- Retires one entry per cycle in order: register writes to RegFile, stores to DataCache via a req/ack handshake.
- Adds branch-mispredict flush with PC redirect, CDB bypass on operand check ports, and a full/empty count that is exact at every depth.

Parameters:
DATA_W, 32, data/result width
ADDR_W, 32, store address / redirect PC width
REG_W, 5, architectural register index width
ENTRY_W, 3, tag width; depth DEPTH = 2**ENTRY_W

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
full  out  1  count == DEPTH
empty  out  1  count == 0
alloc  in  1  dispatch request
alloc_op  in  2  0 empty/nop, 1 branch, 2 store, 3 normal
alloc_reg  in  REG_W  destination register (normal ops)
alloc_tag  out  ENTRY_W  tag the next allocation receives (= tail)
cdb_write  in  1  CDB broadcast valid
cdb_tag  in  ENTRY_W  producing entry
cdb_value  in  DATA_W  result / store data
cdb_aux  in  ADDR_W  store address or branch target
cdb_mispredict  in  1  branch resolved mispredicted
chk_tag1 / chk_tag2  in  ENTRY_W  operand lookup tags
chk_rdy1 / chk_rdy2  out  1  value available
chk_val1 / chk_val2  out  DATA_W  value (0 when not ready)
reg_we  out  1  commit write to RegFile
reg_name  out  REG_W  committed destination
reg_data  out  DATA_W  committed value
reg_tag  out  ENTRY_W  committed entry (RegFile clears its lock if it matches)
mem_req  out  1  store commit request
mem_addr  out  ADDR_W  store address
mem_data  out  DATA_W  store data
mem_ack  in  1  DataCache accepts store this cycle
flush  out  1  mispredict flush pulse
redirect_pc  out  ADDR_W  fetch target when flush=1

Behaviour:
- State: head/tail pointers (ENTRY_W bits, wrap modulo DEPTH) and count (ENTRY_W+1 bits). Per entry: busy, ready, op, reg, value, aux, mispredict.
- Reset: pointers, count and all busy/ready bits are 0. All outputs are then 0, except empty=1.
- Allocate: if alloc && !full && !flush, then at the edge: entry[tail] gets busy=1, ready=(op==0), the op and reg fields; tail++.
- Allocate while full: ignored, no state change. Full is computed from the current count, so a commit in the same cycle does not free a slot for that cycle's alloc.
- CDB: at the edge, if cdb_write && busy[cdb_tag]: ready=1 and value/aux/mispredict are stored. A CDB write to a non-busy entry is ignored.
- Check ports: combinational. If a CDB write to the same tag occurs this cycle, it is bypassed: rdy=1, val=cdb_value. Otherwise rdy = busy && ready and val = stored value. A non-busy tag gives rdy=0, val=0.
- Head-ready condition: H = !empty && ready[head]. All commit outputs below are combinational from the head entry.
  - op 3 (normal): reg_we=H, with reg_name/reg_data/reg_tag from the head. Retires at the edge.
  - op 2 (store): mem_req=H, with mem_addr=aux and mem_data=value. Retires only at an edge where mem_ack=1; held otherwise, with outputs stable.
  - op 1 (branch), mispredict=0: retires silently.
  - op 1 (branch), mispredict=1: flush=H and redirect_pc=aux. At that edge all busy bits are cleared and head=tail=count=0. Alloc and CDB writes in that cycle are dropped.
  - op 0: retires silently.
- Retire: clears busy, head++, count--. Simultaneous alloc and retire leaves count unchanged.
- A CDB write to the head entry takes effect at the edge; commit happens the next cycle (no commit bypass).
- At most one retire per cycle. The head does not advance when empty.
- Reset asserted mid-operation: the same-edge result equals the reset state, regardless of pending store or flush.

Test Plan:
- Reset, then allocate 8 normal ops (ENTRY_W=3) -> alloc_tag 0..7, full=1 after the 8th; a 9th alloc is ignored and tail stays 0.
- Allocate tags 0,1 for r3, r4; CDB tag1=0x22 then tag0=0x11 -> reg_we on consecutive cycles: (r3,0x11,tag0), then (r4,0x22,tag1); empty=1 afterwards.
- Store at the head, CDB value=0xAB, aux=0x100; mem_ack low for 3 cycles -> mem_req=1 with addr 0x100, data 0xAB held stable for 4 cycles; retires on the ack cycle.
- Branch tag0 plus 3 younger entries; CDB tag0 with mispredict=1, aux=0x40 -> flush=1, redirect_pc=0x40 for one cycle; next cycle empty=1, alloc_tag=0.
- chk_tag1=2 while a CDB write to tag2=0x5 occurs in the same cycle -> chk_rdy1=1, chk_val1=0x5 in that cycle; a non-busy tag -> rdy=0, val=0.
- Wrap: ENTRY_W=2, stream 10 allocs interleaved with commits -> tags wrap 3→0, count never exceeds 4, no lost commits.

Source files
------------

// File: rtl/rob_param.sv
// Parametrised in-order-retire reorder buffer: dispatch allocation, CDB capture,
// operand lookup with CDB bypass, RegFile/DataCache commit and mispredict flush.
module rob_param #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 5,
  parameter int ENTRY_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  output logic                full,
  output logic                empty,
  input  logic                alloc,
  input  logic [1:0]          alloc_op,
  input  logic [REG_W-1:0]    alloc_reg,
  output logic [ENTRY_W-1:0]  alloc_tag,
  input  logic                cdb_write,
  input  logic [ENTRY_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0]   cdb_value,
  input  logic [ADDR_W-1:0]   cdb_aux,
  input  logic                cdb_mispredict,
  input  logic [ENTRY_W-1:0]  chk_tag1,
  input  logic [ENTRY_W-1:0]  chk_tag2,
  output logic                chk_rdy1,
  output logic                chk_rdy2,
  output logic [DATA_W-1:0]   chk_val1,
  output logic [DATA_W-1:0]   chk_val2,
  output logic                reg_we,
  output logic [REG_W-1:0]    reg_name,
  output logic [DATA_W-1:0]   reg_data,
  output logic [ENTRY_W-1:0]  reg_tag,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data,
  input  logic                mem_ack,
  output logic                flush,
  output logic [ADDR_W-1:0]   redirect_pc
);

  localparam int DEPTH = 2 ** ENTRY_W;
  localparam logic [ENTRY_W:0] DEPTH_CNT = {1'b1, {ENTRY_W{1'b0}}};
  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_BR  = 2'd1;
  localparam logic [1:0] OP_ST  = 2'd2;
  localparam logic [1:0] OP_ALU = 2'd3;

  logic [ENTRY_W-1:0] head, tail;
  logic [ENTRY_W:0]   count;
  logic [DEPTH-1:0]   busy, ready, mis;
  logic [1:0]         op_q    [DEPTH];
  logic [REG_W-1:0]   reg_q   [DEPTH];
  logic [DATA_W-1:0]  value_q [DEPTH];
  logic [ADDR_W-1:0]  aux_q   [DEPTH];

  logic       head_rdy, commit_alu, commit_st, flush_c, retire, alloc_ok, cdb_ok;
  logic [1:0] head_op;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign alloc_tag = tail;

  assign head_op    = op_q[head];
  assign head_rdy   = !empty && ready[head];
  assign commit_alu = head_rdy && (head_op == OP_ALU);
  assign commit_st  = head_rdy && (head_op == OP_ST);
  assign flush_c    = head_rdy && (head_op == OP_BR) && mis[head];
  assign retire     = head_rdy && !flush_c && ((head_op != OP_ST) || mem_ack);

  // Full is judged on the pre-edge count, so a same-cycle retire never frees a slot early.
  assign alloc_ok = alloc && !full && !flush_c;
  assign cdb_ok   = cdb_write && busy[cdb_tag] && !flush_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      ready <= '0;
    end else if (flush_c) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
      ready <= '0;
    end else begin
      if (cdb_ok) begin
        ready[cdb_tag] <= 1'b1;
      end
      if (alloc_ok) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= (alloc_op == OP_NOP);
        tail        <= tail + 1'b1;
      end
      if (retire) begin
        busy[head] <= 1'b0;
        head       <= head + 1'b1;
      end
      case ({alloc_ok, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; it is only observed through busy/ready-qualified paths.
  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      op_q[tail]  <= alloc_op;
      reg_q[tail] <= alloc_reg;
    end
    if (cdb_ok) begin
      value_q[cdb_tag] <= cdb_value;
      aux_q[cdb_tag]   <= cdb_aux;
      mis[cdb_tag]     <= cdb_mispredict;
    end
  end

  always_comb begin
    chk_rdy1 = 1'b0;
    chk_val1 = '0;
    if (cdb_write && (cdb_tag == chk_tag1)) begin
      chk_rdy1 = 1'b1;
      chk_val1 = cdb_value;
    end else if (busy[chk_tag1] && ready[chk_tag1]) begin
      chk_rdy1 = 1'b1;
      chk_val1 = value_q[chk_tag1];
    end
  end

  always_comb begin
    chk_rdy2 = 1'b0;
    chk_val2 = '0;
    if (cdb_write && (cdb_tag == chk_tag2)) begin
      chk_rdy2 = 1'b1;
      chk_val2 = cdb_value;
    end else if (busy[chk_tag2] && ready[chk_tag2]) begin
      chk_rdy2 = 1'b1;
      chk_val2 = value_q[chk_tag2];
    end
  end

  always_comb begin
    reg_we      = commit_alu;
    reg_name    = '0;
    reg_data    = '0;
    reg_tag     = '0;
    mem_req     = commit_st;
    mem_addr    = '0;
    mem_data    = '0;
    flush       = flush_c;
    redirect_pc = '0;
    if (commit_alu) begin
      reg_name = reg_q[head];
      reg_data = value_q[head];
      reg_tag  = head;
    end
    if (commit_st) begin
      mem_addr = aux_q[head];
      mem_data = value_q[head];
    end
    if (flush_c) begin
      redirect_pc = aux_q[head];
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param: vector table on an 8-entry ROB plus hand sequences
// for full/flush/reset corners and a 4-entry wrap-around stream.
module tb_rob_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 8-entry instance
  logic        full, empty, alloc, cdb_write, cdb_mispredict, chk_rdy1, chk_rdy2;
  logic        reg_we, mem_req, mem_ack, flush;
  logic [1:0]  alloc_op;
  logic [4:0]  alloc_reg, reg_name;
  logic [2:0]  alloc_tag, cdb_tag, chk_tag1, chk_tag2, reg_tag;
  logic [31:0] cdb_value, cdb_aux, chk_val1, chk_val2, reg_data, mem_addr, mem_data, redirect_pc;

  // 4-entry instance
  logic        w_full, w_empty, w_alloc, w_cdb_write, w_chk_rdy1, w_chk_rdy2;
  logic        w_reg_we, w_mem_req, w_flush;
  logic [1:0]  w_alloc_op;
  logic [4:0]  w_alloc_reg, w_reg_name;
  logic [1:0]  w_alloc_tag, w_cdb_tag, w_reg_tag;
  logic [31:0] w_cdb_value, w_chk_val1, w_chk_val2, w_reg_data, w_mem_addr, w_mem_data, w_redirect_pc;

  rob_param #(.DATA_W(32), .ADDR_W(32), .REG_W(5), .ENTRY_W(3)) dut (
    .clk(clk), .rst(rst), .full(full), .empty(empty),
    .alloc(alloc), .alloc_op(alloc_op), .alloc_reg(alloc_reg), .alloc_tag(alloc_tag),
    .cdb_write(cdb_write), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_aux(cdb_aux),
    .cdb_mispredict(cdb_mispredict), .chk_tag1(chk_tag1), .chk_tag2(chk_tag2),
    .chk_rdy1(chk_rdy1), .chk_rdy2(chk_rdy2), .chk_val1(chk_val1), .chk_val2(chk_val2),
    .reg_we(reg_we), .reg_name(reg_name), .reg_data(reg_data), .reg_tag(reg_tag),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .flush(flush), .redirect_pc(redirect_pc)
  );

  rob_param #(.DATA_W(32), .ADDR_W(32), .REG_W(5), .ENTRY_W(2)) dut_w (
    .clk(clk), .rst(rst), .full(w_full), .empty(w_empty),
    .alloc(w_alloc), .alloc_op(w_alloc_op), .alloc_reg(w_alloc_reg), .alloc_tag(w_alloc_tag),
    .cdb_write(w_cdb_write), .cdb_tag(w_cdb_tag), .cdb_value(w_cdb_value), .cdb_aux(32'h0),
    .cdb_mispredict(1'b0), .chk_tag1(2'd0), .chk_tag2(2'd0),
    .chk_rdy1(w_chk_rdy1), .chk_rdy2(w_chk_rdy2), .chk_val1(w_chk_val1), .chk_val2(w_chk_val2),
    .reg_we(w_reg_we), .reg_name(w_reg_name), .reg_data(w_reg_data), .reg_tag(w_reg_tag),
    .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_data(w_mem_data), .mem_ack(1'b0),
    .flush(w_flush), .redirect_pc(w_redirect_pc)
  );

  typedef struct packed {
    logic        alloc;
    logic [1:0]  op;
    logic [4:0]  rg;
    logic        cw;
    logic [2:0]  ctag;
    logic [31:0] cval;
    logic [31:0] caux;
    logic        cmis;
    logic        ack;
    logic [2:0]  c1;
    logic [2:0]  c2;
    logic        e_full;
    logic        e_empty;
    logic [2:0]  e_atag;
    logic        e_rdy1;
    logic [31:0] e_val1;
    logic        e_rdy2;
    logic [31:0] e_val2;
    logic        e_we;
    logic [4:0]  e_rname;
    logic [31:0] e_rdata;
    logic [2:0]  e_rtag;
    logic        e_mreq;
    logic [31:0] e_maddr;
    logic [31:0] e_mdata;
    logic        e_flush;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];
  int passed = 0;
  int total  = 0;

  function automatic vec_t mk(input logic a, input logic [1:0] op, input logic [4:0] rg,
                              input logic cw, input logic [2:0] ct, input logic [31:0] cv,
                              input logic [31:0] ca, input logic cm, input logic ack,
                              input logic [2:0] c1, input logic [2:0] c2,
                              input logic ef, input logic ee, input logic [2:0] ea,
                              input logic r1, input logic [31:0] v1,
                              input logic r2, input logic [31:0] v2);
    vec_t v;
    v = '0;
    v.alloc = a; v.op = op; v.rg = rg;
    v.cw = cw; v.ctag = ct; v.cval = cv; v.caux = ca; v.cmis = cm; v.ack = ack;
    v.c1 = c1; v.c2 = c2;
    v.e_full = ef; v.e_empty = ee; v.e_atag = ea;
    v.e_rdy1 = r1; v.e_val1 = v1; v.e_rdy2 = r2; v.e_val2 = v2;
    return v;
  endfunction

  function automatic vec_t with_reg(input vec_t vi, input logic [4:0] rn, input logic [31:0] rd,
                                    input logic [2:0] rt);
    vec_t v;
    v = vi;
    v.e_we = 1'b1; v.e_rname = rn; v.e_rdata = rd; v.e_rtag = rt;
    return v;
  endfunction

  function automatic vec_t with_st(input vec_t vi, input logic [31:0] ad, input logic [31:0] dt);
    vec_t v;
    v = vi;
    v.e_mreq = 1'b1; v.e_maddr = ad; v.e_mdata = dt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    alloc = 0; alloc_op = 0; alloc_reg = 0;
    cdb_write = 0; cdb_tag = 0; cdb_value = 0; cdb_aux = 0; cdb_mispredict = 0;
    mem_ack = 0; chk_tag1 = 0; chk_tag2 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_in();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic do_alloc(input logic [1:0] op, input logic [4:0] rg);
    clr_in();
    alloc = 1; alloc_op = op; alloc_reg = rg;
    tick();
    clr_in();
  endtask

  // wrap-stream reference model
  int          m_head, m_tail, m_cnt, allocs, commits, next_reg, idx;
  bit          m_busy[4], m_rdy[4];
  logic [4:0]  m_reg[4];
  bit          h, acc, cw_sel;

  initial begin
    w_alloc = 0; w_alloc_op = 0; w_alloc_reg = 0;
    w_cdb_write = 0; w_cdb_tag = 0; w_cdb_value = 0;
    do_reset();

    check("rst empty", empty, 1);
    check("rst full", full, 0);
    check("rst alloc_tag", alloc_tag, 0);
    check("rst reg_we", reg_we, 0);
    check("rst mem_req", mem_req, 0);
    check("rst flush", flush, 0);
    check("rst chk_rdy1", chk_rdy1, 0);
    check("rst w_empty", w_empty, 1);

    // in-order commit, bypass, store handshake, nop and correct-branch retire
    tbl.push_back(mk(1,3,3, 0,0,0,0,0,0, 0,0, 0,1,0, 0,0,0,0));
    tbl.push_back(mk(1,3,4, 0,0,0,0,0,0, 0,1, 0,0,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,1,'h22,0,0,0, 1,0, 0,0,2, 1,'h22,0,0));
    tbl.push_back(mk(0,0,0, 1,0,'h11,0,0,0, 1,0, 0,0,2, 1,'h22,1,'h11));
    tbl.push_back(with_reg(mk(0,0,0, 0,0,0,0,0,0, 0,1, 0,0,2, 1,'h11,1,'h22), 3, 'h11, 0));
    tbl.push_back(with_reg(mk(0,0,0, 0,0,0,0,0,0, 1,0, 0,0,2, 1,'h22,0,0), 4, 'h22, 1));
    tbl.push_back(mk(0,0,0, 0,0,0,0,0,0, 1,0, 0,1,2, 0,0,0,0));
    tbl.push_back(mk(1,2,0, 0,0,0,0,0,0, 2,2, 0,1,2, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,2,'hAB,'h100,0,0, 2,3, 0,0,3, 1,'hAB,0,0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(with_st(mk(0,0,0, 0,0,0,0,0,0, 2,3, 0,0,3, 1,'hAB,0,0), 'h100, 'hAB));
    tbl.push_back(with_st(mk(0,0,0, 0,0,0,0,0,1, 2,3, 0,0,3, 1,'hAB,0,0), 'h100, 'hAB));
    tbl.push_back(mk(0,0,0, 0,0,0,0,0,0, 2,3, 0,1,3, 0,0,0,0));
    tbl.push_back(mk(1,0,0, 0,0,0,0,0,0, 0,0, 0,1,3, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0,0,0, 0,0, 0,0,4, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0,0,0, 0,0, 0,1,4, 0,0,0,0));
    tbl.push_back(mk(1,1,0, 0,0,0,0,0,0, 0,0, 0,1,4, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,4,0,'h80,0,0, 0,0, 0,0,5, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0,0,0, 0,0, 0,0,5, 0,0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0,0,0,0, 0,0, 0,1,5, 0,0,0,0));

    foreach (tbl[i]) begin
      alloc = tbl[i].alloc; alloc_op = tbl[i].op; alloc_reg = tbl[i].rg;
      cdb_write = tbl[i].cw; cdb_tag = tbl[i].ctag; cdb_value = tbl[i].cval;
      cdb_aux = tbl[i].caux; cdb_mispredict = tbl[i].cmis; mem_ack = tbl[i].ack;
      chk_tag1 = tbl[i].c1; chk_tag2 = tbl[i].c2;
      #1;
      check($sformatf("v%0d full", i), full, tbl[i].e_full);
      check($sformatf("v%0d empty", i), empty, tbl[i].e_empty);
      check($sformatf("v%0d alloc_tag", i), alloc_tag, tbl[i].e_atag);
      check($sformatf("v%0d chk_rdy1", i), chk_rdy1, tbl[i].e_rdy1);
      check($sformatf("v%0d chk_val1", i), chk_val1, tbl[i].e_val1);
      check($sformatf("v%0d chk_rdy2", i), chk_rdy2, tbl[i].e_rdy2);
      check($sformatf("v%0d chk_val2", i), chk_val2, tbl[i].e_val2);
      check($sformatf("v%0d reg_we", i), reg_we, tbl[i].e_we);
      check($sformatf("v%0d reg_name", i), reg_name, tbl[i].e_rname);
      check($sformatf("v%0d reg_data", i), reg_data, tbl[i].e_rdata);
      check($sformatf("v%0d reg_tag", i), reg_tag, tbl[i].e_rtag);
      check($sformatf("v%0d mem_req", i), mem_req, tbl[i].e_mreq);
      check($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].e_maddr);
      check($sformatf("v%0d mem_data", i), mem_data, tbl[i].e_mdata);
      check($sformatf("v%0d flush", i), flush, tbl[i].e_flush);
      check($sformatf("v%0d redirect_pc", i), redirect_pc, tbl[i].e_pc);
      tick();
    end
    clr_in();

    // fill to full, ignored 9th alloc, commit does not free a slot in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc = 1; alloc_op = 3; alloc_reg = 5'(i + 1);
      #1;
      check($sformatf("fill%0d alloc_tag", i), alloc_tag, i);
      check($sformatf("fill%0d full", i), full, 0);
      tick();
    end
    check("full after 8", full, 1);
    check("full alloc_tag", alloc_tag, 0);
    alloc = 1; alloc_op = 3; alloc_reg = 9;
    tick();
    check("9th ignored full", full, 1);
    check("9th ignored tail", alloc_tag, 0);
    clr_in();
    cdb_write = 1; cdb_tag = 0; cdb_value = 'h99;
    tick();
    clr_in();
    alloc = 1; alloc_op = 3; alloc_reg = 7;
    #1;
    check("full+commit reg_we", reg_we, 1);
    check("full+commit reg_name", reg_name, 1);
    check("full+commit reg_data", reg_data, 'h99);
    tick();
    check("full+commit not full", full, 0);
    check("full+commit tail", alloc_tag, 0);
    check("full+commit empty", empty, 0);
    tick();
    check("refill full", full, 1);
    check("refill tail", alloc_tag, 1);

    // reset asserted with a committable head and an alloc pending
    clr_in();
    cdb_write = 1; cdb_tag = 1; cdb_value = 'h5A;
    tick();
    clr_in();
    #1;
    check("pre-rst reg_we", reg_we, 1);
    rst = 1; alloc = 1; alloc_op = 3;
    tick();
    rst = 0;
    clr_in();
    #1;
    check("mid-rst empty", empty, 1);
    check("mid-rst full", full, 0);
    check("mid-rst alloc_tag", alloc_tag, 0);
    check("mid-rst reg_we", reg_we, 0);

    // mispredict flush drops same-cycle alloc and CDB write
    do_reset();
    do_alloc(1, 0);
    do_alloc(3, 5);
    do_alloc(3, 6);
    do_alloc(3, 7);
    check("pre-flush alloc_tag", alloc_tag, 4);
    cdb_write = 1; cdb_tag = 0; cdb_mispredict = 1; cdb_aux = 'h40;
    #1;
    check("cdb-cycle flush", flush, 0);
    tick();
    clr_in();
    alloc = 1; alloc_op = 3; alloc_reg = 8;
    cdb_write = 1; cdb_tag = 1; cdb_value = 'h77;
    #1;
    check("flush pulse", flush, 1);
    check("redirect_pc", redirect_pc, 'h40);
    check("flush reg_we", reg_we, 0);
    tick();
    clr_in();
    chk_tag1 = 1;
    #1;
    check("post-flush flush", flush, 0);
    check("post-flush empty", empty, 1);
    check("post-flush alloc_tag", alloc_tag, 0);
    check("post-flush chk_rdy1", chk_rdy1, 0);
    check("post-flush chk_val1", chk_val1, 0);
    tick();
    check("post-flush stays empty", empty, 1);

    // 4-entry wrap stream
    m_head = 0; m_tail = 0; m_cnt = 0; allocs = 0; commits = 0; next_reg = 1;
    for (int k = 0; k < 4; k++) begin m_busy[k] = 0; m_rdy[k] = 0; m_reg[k] = 0; end
    for (int t = 0; t < 200 && commits < 10; t++) begin
      w_alloc = (allocs < 10) && (t % 3 != 2);
      w_alloc_op = 3;
      w_alloc_reg = 5'(allocs + 1);
      cw_sel = 0; idx = 0;
      if (t % 2 == 1) begin
        for (int k = 0; k < 4; k++) begin
          if (!cw_sel && k < m_cnt && m_busy[(m_head + k) % 4] && !m_rdy[(m_head + k) % 4]) begin
            cw_sel = 1;
            idx = (m_head + k) % 4;
          end
        end
      end
      w_cdb_write = cw_sel;
      w_cdb_tag = 2'(idx);
      w_cdb_value = 32'h50 + 32'(m_reg[idx]);
      #1;
      h = (m_cnt != 0) && m_rdy[m_head];
      check($sformatf("wrap t%0d full", t), w_full, m_cnt == 4);
      check($sformatf("wrap t%0d empty", t), w_empty, m_cnt == 0);
      check($sformatf("wrap t%0d alloc_tag", t), w_alloc_tag, m_tail);
      check($sformatf("wrap t%0d reg_we", t), w_reg_we, h);
      if (h) begin
        check($sformatf("wrap t%0d reg_name", t), w_reg_name, next_reg);
        check($sformatf("wrap t%0d reg_data", t), w_reg_data, 32'h50 + next_reg);
        check($sformatf("wrap t%0d reg_tag", t), w_reg_tag, m_head);
      end
      acc = w_alloc && (m_cnt != 4);
      if (h) begin
        m_busy[m_head] = 0;
        m_head = (m_head + 1) % 4;
        m_cnt--;
        commits++;
        next_reg++;
      end
      if (cw_sel) m_rdy[idx] = 1;
      if (acc) begin
        m_busy[m_tail] = 1;
        m_rdy[m_tail] = 0;
        m_reg[m_tail] = 5'(allocs + 1);
        m_tail = (m_tail + 1) % 4;
        m_cnt++;
        allocs++;
      end
      tick();
    end
    w_alloc = 0; w_cdb_write = 0;
    #1;
    check("wrap commits", commits, 10);
    check("wrap final empty", w_empty, 1);
    check("wrap final tail", w_alloc_tag, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
